// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment counter monitor:
// segment codes for digits 0..7, tracking states and stability-counter width.
package seg_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational decode of an active-high seven-segment pattern into a digit 0..7;
// is_digit is low for any pattern outside the table.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] digit,
  output logic       is_digit
);

  always_comb begin
    digit    = 3'd0;
    is_digit = 1'b1;
    case (pattern)
      SEG_0:   digit = 3'd0;
      SEG_1:   digit = 3'd1;
      SEG_2:   digit = 3'd2;
      SEG_3:   digit = 3'd3;
      SEG_4:   digit = 3'd4;
      SEG_5:   digit = 3'd5;
      SEG_6:   digit = 3'd6;
      SEG_7:   digit = 3'd7;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_monitor.sv
// Watches the segment drive of a 3-bit counter, debounces it, and flags
// illegal patterns and counting steps that disagree with enable/dir.
module seg_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] lights,
  input  logic       enable,
  input  logic       dir,
  output logic [2:0] value,
  output logic       valid,
  output logic       new_value,
  output logic       bad_pattern,
  output logic       step_err,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [6:0]       lights_eff;
  logic [6:0]       samp;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic [2:0]       digit;
  logic             is_digit;
  logic             accept;
  logic [2:0]       expected;
  logic             step_bad;
  logic [7:0]       err_inc;

  assign lights_eff = (ACTIVE_LOW != 0) ? ~lights : lights;

  seg_decode u_decode (
    .pattern  (samp),
    .digit    (digit),
    .is_digit (is_digit)
  );

  // Acceptance is the edge on which the run of equal samples completes.
  assign accept   = (lights_eff == samp) && (cnt == STABLE - CNT_W'(1));
  assign expected = dir ? value + 3'd1 : value - 3'd1;
  assign step_bad = !enable || (digit != expected);
  assign err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp        <= 7'd0;
      cnt         <= '0;
      state       <= SYNC;
      value       <= 3'd0;
      valid       <= 1'b0;
      new_value   <= 1'b0;
      bad_pattern <= 1'b0;
      step_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      samp        <= lights_eff;
      new_value   <= 1'b0;
      bad_pattern <= 1'b0;
      step_err    <= 1'b0;

      if (lights_eff != samp) begin
        cnt <= '0;
      end else if (cnt != STABLE) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end

      if (accept) begin
        if (!is_digit) begin
          bad_pattern <= 1'b1;
          err_count   <= err_inc;
          state       <= SYNC;
          valid       <= 1'b0;
        end else begin
          case (state)
            SYNC: begin
              value     <= digit;
              new_value <= 1'b1;
              state     <= TRACK;
              valid     <= 1'b1;
            end
            TRACK: begin
              // Returning to the digit already held is treated as a glitch.
              if (digit != value) begin
                value     <= digit;
                new_value <= 1'b1;
                if (step_bad) begin
                  step_err  <= 1'b1;
                  err_count <= err_inc;
                end
              end
            end
            default: begin
              state <= SYNC;
              valid <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_monitor.sv
// Self-checking bench for seg_monitor: directed table, reset/saturation
// sequences, then randomized segments against a run-length reference model.
module tb_seg_monitor;

  localparam int STABLE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] lights;
  logic       enable;
  logic       dir;
  logic [2:0] value;
  logic       valid;
  logic       new_value;
  logic       bad_pattern;
  logic       step_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  seg_monitor #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .lights      (lights),
    .enable      (enable),
    .dir         (dir),
    .value       (value),
    .valid       (valid),
    .new_value   (new_value),
    .bad_pattern (bad_pattern),
    .step_err    (step_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] l;
    logic       en;
    logic       d;
    int         hold;
    logic       e_new;
    logic       e_bad;
    logic       e_step;
    logic [2:0] e_val;
    logic       e_valid;
    int         e_err;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] codes [8];

  // Reference model: run length of the current sample and the tracked digit.
  logic [6:0] m_samp;
  int         m_run;
  bit         m_track;
  int         m_val;
  int         m_err;
  bit         m_new, m_bad, m_step;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 8; i++) if (codes[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_samp = 7'd0; m_run = 1; m_track = 0; m_val = 0; m_err = 0;
    m_new = 0; m_bad = 0; m_step = 0;
  endtask

  task automatic model_edge(input logic [6:0] l, input logic e, input logic d);
    int k;
    int exp_d;
    if (l == m_samp) m_run++;
    else begin m_samp = l; m_run = 1; end
    m_new = 0; m_bad = 0; m_step = 0;
    if (m_run == STABLE + 1) begin
      k = dec(m_samp);
      if (k < 0) begin
        m_bad = 1; m_track = 0;
        if (m_err < 255) m_err++;
      end else if (!m_track) begin
        m_val = k; m_new = 1; m_track = 1;
      end else if (k != m_val) begin
        exp_d = d ? (m_val + 1) % 8 : (m_val + 7) % 8;
        if (!e || k != exp_d) begin
          m_step = 1;
          if (m_err < 255) m_err++;
        end
        m_val = k; m_new = 1;
      end
    end
  endtask

  task automatic edge_once(input logic [6:0] l, input logic e, input logic d);
    lights = l; enable = e; dir = d;
    @(posedge clk);
    #1;
    model_edge(l, e, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(input logic [6:0] l, input logic en, input logic d, input int hold,
                              input logic nv, input logic bp, input logic se,
                              input logic [2:0] v, input logic vl, input int er);
    vec_t r;
    r.l = l; r.en = en; r.d = d; r.hold = hold; r.e_new = nv; r.e_bad = bp;
    r.e_step = se; r.e_val = v; r.e_valid = vl; r.e_err = er;
    return r;
  endfunction

  initial begin
    int k;
    logic [6:0] pat;
    logic e, d;
    int hold;

    codes[0] = 7'h3F; codes[1] = 7'h06; codes[2] = 7'h5B; codes[3] = 7'h4F;
    codes[4] = 7'h66; codes[5] = 7'h6D; codes[6] = 7'h7D; codes[7] = 7'h07;

    // Directed vectors: each applied for 'hold' edges, full check on the last.
    tbl.push_back(mk(7'h3F, 1, 1, 3, 1, 0, 0, 0, 1, 0));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(codes[i], 1, 1, 3, 1, 0, 0, 3'(i), 1, 0));
    tbl.push_back(mk(7'h3F, 1, 1, 3, 1, 0, 0, 0, 1, 0));
    for (int i = 1; i < 4; i++) tbl.push_back(mk(codes[i], 1, 1, 3, 1, 0, 0, 3'(i), 1, 0));
    tbl.push_back(mk(7'h5B, 1, 1, 3, 1, 0, 1, 2, 1, 1));
    tbl.push_back(mk(7'h7F, 1, 1, 3, 0, 1, 0, 2, 0, 2));
    tbl.push_back(mk(7'h06, 1, 1, 3, 1, 0, 0, 1, 1, 2));
    tbl.push_back(mk(7'h3F, 1, 0, 3, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(7'h07, 1, 0, 3, 1, 0, 0, 7, 1, 2));
    tbl.push_back(mk(7'h3F, 0, 1, 3, 1, 0, 1, 0, 1, 3));
    for (int i = 1; i < 5; i++) tbl.push_back(mk(codes[i], 1, 1, 3, 1, 0, 0, 3'(i), 1, 3));
    tbl.push_back(mk(7'h6D, 1, 1, 1, 0, 0, 0, 4, 1, 3));
    tbl.push_back(mk(7'h66, 1, 1, 3, 0, 0, 0, 4, 1, 3));

    lights = 7'h3F; enable = 1'b1; dir = 1'b1;
    do_reset();
    chk("reset_value", value, 0);
    chk("reset_valid", valid, 0);
    chk("reset_err", err_count, 0);
    chk("reset_new", new_value, 0);

    for (int v = 0; v < tbl.size(); v++) begin
      for (int h = 1; h <= tbl[v].hold; h++) begin
        edge_once(tbl[v].l, tbl[v].en, tbl[v].d);
        if (h < tbl[v].hold) begin
          chk($sformatf("v%0d_mid_pulses", v), {new_value, bad_pattern, step_err}, 0);
        end else begin
          chk($sformatf("v%0d_new", v), new_value, tbl[v].e_new);
          chk($sformatf("v%0d_bad", v), bad_pattern, tbl[v].e_bad);
          chk($sformatf("v%0d_step", v), step_err, tbl[v].e_step);
          chk($sformatf("v%0d_value", v), value, tbl[v].e_val);
          chk($sformatf("v%0d_valid", v), valid, tbl[v].e_valid);
          chk($sformatf("v%0d_err", v), err_count, tbl[v].e_err);
        end
      end
    end

    // Reset between edges while a new pattern is still qualifying.
    edge_once(7'h06, 1, 1);
    edge_once(7'h06, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_value", value, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_pulses", {new_value, bad_pattern, step_err}, 0);
    #1;
    reset = 1'b0;
    model_reset();
    edge_once(7'h06, 1, 1);
    edge_once(7'h06, 1, 1);
    chk("requal_no_early", new_value, 0);
    edge_once(7'h06, 1, 1);
    chk("requal_new", new_value, 1);
    chk("requal_value", value, 1);
    chk("requal_valid", valid, 1);

    // Saturate the error counter with alternating invalid patterns.
    for (int i = 0; i < 300; i++) begin
      pat = (i % 2 == 0) ? 7'h00 : 7'h7F;
      repeat (3) edge_once(pat, 1, 1);
      if (i == 99) chk("err_100", err_count, 100);
    end
    chk("err_sat", err_count, 255);
    chk("sat_valid", valid, 0);
    edge_once(7'h00, 1, 1);
    chk("err_sat_hold", err_count, 255);

    // Randomized segments checked edge by edge against the model.
    lights = 7'h3F;
    do_reset();
    for (int s = 0; s < 200; s++) begin
      k = $urandom_range(0, 9);
      if (k < 6) pat = codes[(m_val + (($urandom_range(0, 1) != 0) ? 1 : 7)) % 8];
      else if (k < 8) pat = codes[$urandom_range(0, 7)];
      else pat = 7'($urandom_range(0, 127));
      e = ($urandom_range(0, 7) != 0);
      d = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        edge_once(pat, e, d);
        chk("rnd_new", new_value, m_new);
        chk("rnd_bad", bad_pattern, m_bad);
        chk("rnd_step", step_err, m_step);
        chk("rnd_valid", valid, m_track);
        chk("rnd_err", err_count, m_err);
        if (m_track) chk("rnd_value", value, m_val);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_monitor.md
SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, is the number of additional consecutive equal samples required before a lights pattern is accepted; legal range 1..15.
REQ-002 Parameter ACTIVE_LOW, default 0, when 1 inverts lights before decoding.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 lights  input  7  seven-segment drive, bit0=a ... bit6=g, active-high unless ACTIVE_LOW=1.
REQ-006 enable  input  1  counter enable currently applied to the monitored counter.
REQ-007 dir  input  1  counter direction: 1=up, 0=down.
REQ-008 value  output  3  last accepted decoded digit.
REQ-009 valid  output  1  high while value holds a decoded digit (state TRACK).
REQ-010 new_value  output  1  one-cycle pulse when a new digit is accepted.
REQ-011 bad_pattern  output  1  one-cycle pulse when a stable non-digit pattern is accepted.
REQ-012 step_err  output  1  one-cycle pulse when an accepted digit violates the expected step.
REQ-013 err_count  output  8  saturating count of bad_pattern plus step_err events.

Function
REQ-014 lights shall be registered into samp on every edge; decoding shall use samp only.
REQ-015 Decode table (active-high): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07; any other pattern is invalid.
REQ-016 Stability counter: cleared to 0 when samp differs from its previous value; otherwise incremented, saturating at STABLE_CYCLES.
REQ-017 Acceptance fires on the single edge where the counter first reaches STABLE_CYCLES; with STABLE_CYCLES=2, the pulse is high after the 3rd edge that samples the new pattern.
REQ-018 Patterns held for fewer edges than needed for acceptance shall be ignored, with no output change.
REQ-019 States: SYNC (no reference digit) and TRACK; reset enters SYNC.
REQ-020 SYNC, valid digit accepted: load value, pulse new_value, go to TRACK, no step check.
REQ-021 TRACK, accepted digit equal to value: no pulse (glitch returning to same digit).
REQ-022 TRACK, accepted digit different from value: expected = value+1 mod 8 if dir=1, value-1 mod 8 if dir=0; dir and enable are sampled on the acceptance edge.
REQ-023 Mismatch, or any change while enable=0: pulse step_err and increment err_count. In all cases load value and pulse new_value.
REQ-024 Wrap-around: 7->0 with dir=1 and 0->7 with dir=0 are legal steps.
REQ-025 Invalid pattern accepted, in either state: pulse bad_pattern, increment err_count, go to SYNC, value holds, valid=0.
REQ-026 err_count saturates at 255. bad_pattern and step_err are mutually exclusive by construction.

Reset
REQ-027 Reset asserted: samp=0, stability counter=0, state=SYNC, value=0, valid=0, all pulses=0, err_count=0, immediately and independent of clk.
REQ-028 Reset mid-acceptance discards the pending pattern. After release, the current pattern shall be re-qualified from a count of 0.

Structure
REQ-029 Package seg_pkg shall hold the eight segment-code constants, the state enum (SYNC, TRACK) and the stability-counter width.
REQ-030 Sub-module seg_decode (combinational, 7-bit pattern -> 3-bit digit plus is_digit) shall be instantiated once.

Verification
REQ-031 Reset, then lights=0x3F held 3 edges -> new_value pulse after 3rd edge, value=0, valid=1, err_count=0.
REQ-032 dir=1, enable=1, sequence 0..7,0 each held 4 edges -> nine new_value pulses, no step_err, value wraps to 0.
REQ-033 value=3, lights=0x5B (2) with dir=1 -> step_err pulse, err_count=1, value=2.
REQ-034 lights=0x7F held 3 edges -> bad_pattern, valid=0, SYNC. Then 0x06 -> value=1, no step_err.
REQ-035 value=4, 0x6D pulsed for 1 edge, then back to 0x66 -> no pulses.
REQ-036 Reset asserted between edges mid-qualification -> outputs cleared immediately; 300 injected errors -> err_count=255.
